// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard controller: stage indices and forward-select priority.
`include "cpu_defs.vh"

package hazard_ctrl_pkg;

  // Tracking stages, youngest first.
  localparam int unsigned NumStages = 3;
  localparam int unsigned StageEx   = 0;
  localparam int unsigned StageMem  = 1;
  localparam int unsigned StageWb   = 2;

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] fwd_sel(input logic [NumStages-1:0] hit);
    logic [1:0] sel;
    sel = `FWD_RF;
    if (hit[StageEx]) begin
      sel = `FWD_EX;
    end else if (hit[StageMem]) begin
      sel = `FWD_MEM;
    end else if (hit[StageWb]) begin
      sel = `FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cpu_defs.vh
// Shared CPU definitions: forwarding-select encodings, GPR address width and zero register.
`ifndef CPU_DEFS_VH
`define CPU_DEFS_VH

`define FWD_RF   2'b00
`define FWD_EX   2'b01
`define FWD_MEM  2'b10
`define FWD_WB   2'b11

`define GPR_W    5
`define ZERO_REG 5'd0

`endif

// File: rtl/hazard_cmp.sv
// Per-source hit compare against one tracking entry. Register 0 never hits.
`include "cpu_defs.vh"

module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = `GPR_W
) (
  input  logic             valid,
  input  logic             wreg,
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  output logic             hit
);

  // Entry produces a value the source is actually about to read.
  always_comb begin
    hit = valid & wreg & use_src & (dest != REG_W'(`ZERO_REG)) & (dest == src);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks ID destinations through EX/MEM/WB, drives stall, bubble
// and operand forwarding selects, and counts stalled cycles (saturating).
// Optional feature macro: HAZARD_FORWARDING_EN (forwarding + load-use stall). When undefined,
// any live producer stalls ID and operands always come from the register file.
`include "cpu_defs.vh"

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = `GPR_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Tracking entries indexed by stage (0=EX, 1=MEM, 2=WB). Only EX ever needs the load flag,
  // since a load is forwardable once it reaches MEM.
  logic [NumStages-1:0] ent_valid_q;
  logic [NumStages-1:0] ent_wreg_q;
  logic [REG_W-1:0]     ent_dest_q [NumStages];
  logic                 ex_m2reg_q;

  logic [NumStages-1:0] hit_a;
  logic [NumStages-1:0] hit_b;
  logic                 load_use;
  logic [CNT_W-1:0]     stall_count_q;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    hazard_cmp #(
      .REG_W (REG_W)
    ) u_cmp_a (
      .valid   (ent_valid_q[s]),
      .wreg    (ent_wreg_q[s]),
      .dest    (ent_dest_q[s]),
      .src     (id_rs),
      .use_src (id_use_rs),
      .hit     (hit_a[s])
    );

    hazard_cmp #(
      .REG_W (REG_W)
    ) u_cmp_b (
      .valid   (ent_valid_q[s]),
      .wreg    (ent_wreg_q[s]),
      .dest    (ent_dest_q[s]),
      .src     (id_rt),
      .use_src (id_use_rt),
      .hit     (hit_b[s])
    );
  end

  // Load in EX feeding a used source: data not available until MEM.
  always_comb begin
    load_use = ex_m2reg_q & (hit_a[StageEx] | hit_b[StageEx]);
  end

  // Hazard outputs; flush squashes the ID instruction and overrides any stall.
  always_comb begin
    stall = 1'b0;
    fwd_a = `FWD_RF;
    fwd_b = `FWD_RF;
    if (id_valid) begin
`ifdef HAZARD_FORWARDING_EN
      stall = load_use & ~flush;
      fwd_a = fwd_sel(hit_a);
      fwd_b = fwd_sel(hit_b);
`else
      // load_use is a subset of the any-hit term; it is kept so both builds share one view.
      stall = ((|hit_a) | (|hit_b) | load_use) & ~flush;
`endif
    end
    bubble = stall | flush;
  end

  // Entry shift register: tracking never freezes, a bubble enters EX as an invalid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_q <= '0;
      ent_wreg_q  <= '0;
      ent_dest_q  <= '{default: '0};
      ex_m2reg_q  <= 1'b0;
    end else begin
      ent_valid_q[StageWb]  <= ent_valid_q[StageMem];
      ent_wreg_q[StageWb]   <= ent_wreg_q[StageMem];
      ent_dest_q[StageWb]   <= ent_dest_q[StageMem];
      ent_valid_q[StageMem] <= ent_valid_q[StageEx];
      ent_wreg_q[StageMem]  <= ent_wreg_q[StageEx];
      ent_dest_q[StageMem]  <= ent_dest_q[StageEx];
      ent_valid_q[StageEx]  <= id_valid & ~bubble;
      ent_wreg_q[StageEx]   <= id_wreg & ~bubble;
      ent_dest_q[StageEx]   <= bubble ? '0 : id_dest;
      ex_m2reg_q            <= id_m2reg & ~bubble;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != CntMax)) begin
      stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a model built from the last three issued instructions. A second instance with a
// 2-bit counter exercises saturation. Honours HAZARD_FORWARDING_EN like the design.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        id_wreg = 1'b0;
  logic        id_m2reg = 1'b0;
  logic        flush = 1'b0;

  logic        stall, bubble, stall2, bubble2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .flush(flush), .stall(stall), .bubble(bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_count(stall_count)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .flush(flush), .stall(stall2), .bubble(bubble2), .fwd_a(fwd_a2),
    .fwd_b(fwd_b2), .stall_count(stall_count2)
  );

  // ---------------- reference model ----------------
  // hist[0] is the most recently issued instruction, hist[2] the oldest still unwritten.
  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       w;
    logic       ld;
  } instr_t;

  instr_t      hist [3];
  int unsigned m_cnt;
  int unsigned m_cnt2;

  function automatic logic produces(input int k, input logic [4:0] src, input logic used);
    return used && hist[k].v && hist[k].w && (hist[k].d != 5'd0) && (hist[k].d == src);
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] src, input logic used);
    for (int k = 0; k < 3; k++) begin
      if (produces(k, src, used)) return 2'(k + 1);
    end
    return 2'b00;
  endfunction

  // Expected {stall, bubble, fwd_a, fwd_b} from current ID inputs and history.
  function automatic logic [5:0] m_out();
    logic       st;
    logic       any;
    logic [1:0] fa, fb;
    st = 1'b0; fa = 2'b00; fb = 2'b00; any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      any = any | produces(k, id_rs, id_use_rs) | produces(k, id_rt, id_use_rt);
    end
    if (id_valid && !flush) begin
`ifdef HAZARD_FORWARDING_EN
      st = hist[0].ld && (produces(0, id_rs, id_use_rs) || produces(0, id_rt, id_use_rt));
`else
      st = any;
`endif
    end
`ifdef HAZARD_FORWARDING_EN
    if (id_valid) begin
      fa = m_sel(id_rs, id_use_rs);
      fb = m_sel(id_rt, id_use_rt);
    end
`endif
    return {st, st | flush, fa, fb};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
      m_cnt   <= 0;
      m_cnt2  <= 0;
    end else begin
      logic [5:0] e;
      e = m_out();
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= e[4] ? instr_t'('0) : instr_t'({id_valid, id_dest, id_wreg, id_m2reg});
      if (e[5]) begin
        if (m_cnt < 65535) m_cnt <= m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] d,
                       input logic w, input logic ld, input logic f);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_wreg = w; id_m2reg = ld; flush = f;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({stall, bubble, fwd_a, fwd_b, stall_count} !== 22'd0) begin
      bad++;
      $display("FAIL reset_cold: got %b/%b/%b/%b/%0d want all zero",
               stall, bubble, fwd_a, fwd_b, stall_count);
    end
    // lw $8, then a reader of $8 stalls once; then another reader is live on the load.
    tick();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();
    drive(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0); tick();
    drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    @(negedge clk);
    total++;
`ifdef HAZARD_FORWARDING_EN
    if (fwd_a !== 2'b10) begin
      bad++; $display("FAIL reset_pre_fwd: got %b want 10", fwd_a);
    end
`else
    if (stall !== 1'b1) begin
      bad++; $display("FAIL reset_pre_stall: got %b want 1", stall);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({stall, bubble, fwd_a, fwd_b, stall_count} !== 22'd0) begin
      bad++;
      $display("FAIL reset_async: got %b/%b/%b/%b/%0d want all zero",
               stall, bubble, fwd_a, fwd_b, stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, bubble, fwd_a, fwd_b} !== 6'd0) begin
      bad++; $display("FAIL reset_release: got %b/%b/%b/%b want 0/0/00/00",
                      stall, bubble, fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_alu_dep();
`ifdef HAZARD_FORWARDING_EN
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11;
    for (int gap = 0; gap < 3; gap++) begin
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();   // add $3,$1,$2
      for (int n = 0; n < gap; n++) begin nop(); tick(); end
      drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);           // sub $4,$3,$5
      @(negedge clk);
      total++;
      if ({stall, fwd_a, fwd_b} !== {1'b0, want[gap], 2'b00}) begin
        bad++; $display("FAIL alu_dep_gap%0d: got stall=%b fwd_a=%b fwd_b=%b want 0/%b/00",
                        gap, stall, fwd_a, fwd_b, want[gap]);
      end
      tick();
    end
`else
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();     // add $3,$1,$2
    drive(1, 5'd3, 5'd1, 1, 1, 5'd2, 1, 0, 0);             // or $2,$3,$1, held while stalled
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({stall, bubble, fwd_a} !== 4'b1100) begin
        bad++; $display("FAIL nofwd_stall_c%0d: got stall=%b bubble=%b fwd_a=%b want 1/1/00",
                        c, stall, bubble, fwd_a);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({stall, fwd_a, stall_count} !== {1'b0, 2'b00, 16'd3}) begin
      bad++; $display("FAIL nofwd_release: got stall=%b fwd_a=%b count=%0d want 0/00/3",
                      stall, fwd_a, stall_count);
    end
    tick();
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();     // lw $8,0($1)
    drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);             // add $9,$8,$8
    @(negedge clk);
    total++;
    if ({stall, bubble, stall_count} !== {2'b11, 16'd0}) begin
      bad++; $display("FAIL load_use_stall: got stall=%b bubble=%b count=%0d want 1/1/0",
                      stall, bubble, stall_count);
    end
    tick();
`ifdef HAZARD_FORWARDING_EN
    @(negedge clk);
    total++;
    if ({stall, bubble, fwd_a, fwd_b, stall_count} !== {2'b00, 2'b10, 2'b10, 16'd1}) begin
      bad++; $display("FAIL load_use_fwd: got %b/%b/%b/%b/%0d want 0/0/10/10/1",
                      stall, bubble, fwd_a, fwd_b, stall_count);
    end
    tick();
`endif
  endtask

  task automatic test_zero_unused();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); tick();     // write $0
    drive(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0);             // read $0,$0
    @(negedge clk);
    total++;
    if ({stall, bubble, fwd_a, fwd_b} !== 6'd0) begin
      bad++; $display("FAIL zero_reg: got %b/%b/%b/%b want 0/0/00/00",
                      stall, bubble, fwd_a, fwd_b);
    end
    tick();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0); tick();     // write $7
    drive(1, 5'd1, 5'd7, 1, 0, 5'd7, 1, 0, 0);             // addi $7,$1,imm (rt not read)
    @(negedge clk);
    total++;
    if ({stall, fwd_a, fwd_b} !== 5'd0) begin
      bad++; $display("FAIL unused_rt: got stall=%b fwd_a=%b fwd_b=%b want 0/00/00",
                      stall, fwd_a, fwd_b);
    end
    tick();
    do_reset();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();     // lw $8
    drive(0, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);             // invalid ID reading $8
    @(negedge clk);
    total++;
    if ({stall, bubble, fwd_a, fwd_b} !== 6'd0) begin
      bad++; $display("FAIL id_invalid: got %b/%b/%b/%b want 0/0/00/00",
                      stall, bubble, fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();     // lw $8
    drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 1);             // add $9,$8,$8 with flush
    @(negedge clk);
    total++;
    if ({stall, bubble} !== 2'b01) begin
      bad++; $display("FAIL flush_hazard: got stall=%b bubble=%b want 0/1", stall, bubble);
    end
    tick();
    nop();
    @(negedge clk);
    total++;
    if (stall_count !== 16'd0) begin
      bad++; $display("FAIL flush_count: got %0d want 0", stall_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    // Alternate lw $8 / reader of $8: every reader cycle stalls in both builds.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      else            drive(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0);
      tick();
    end
    nop();
    @(negedge clk);
    total++;
    if (stall_count2 !== 2'd3) begin
      bad++; $display("FAIL saturate_narrow: got %0d want 3", stall_count2);
    end
    total++;
    if (stall_count !== 16'd5) begin
      bad++; $display("FAIL saturate_wide: got %0d want 5", stall_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0));
      @(negedge clk);
      e = m_out();
      total++;
      if ({stall, bubble, fwd_a, fwd_b} !== e) begin
        bad++; $display("FAIL random_out[%0d]: got %b%b_%b_%b want %b", i,
                        stall, bubble, fwd_a, fwd_b, e);
      end
      total++;
      if ((stall_count !== 16'(m_cnt)) || (stall_count2 !== 2'(m_cnt2))) begin
        bad++; $display("FAIL random_count[%0d]: got %0d/%0d want %0d/%0d", i,
                        stall_count, stall_count2, m_cnt, m_cnt2);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_dep();
    test_load_use();
    test_zero_unused();
    test_flush_hazard();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
